writeback_arbiter: RTL and testbench

Parametrised successor to the two-input writeback mux. It collects writeback results from NUM_UNITS functional units (FX, LS, FP, branch, trap…), each through its own FIFO with ready/valid backpressure. One result per cycle is issued to the register-file write port using round-robin arbitration. It sits between the execution units and the register file/writeback stage, and adds queuing, fairness, and downstream stall support that the plain mux lacks.

---
 rtl/writeback_arbiter_if.sv | 53 +++++
 rtl/writeback_arbiter.sv | 138 +++++++++++++
 tb/tb_writeback_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_if.sv
// Bundle of per-unit writeback inputs and the single registered writeback output.
// Wide per-channel buses pack channel 0 at the MSBs; 1-bit-per-channel vectors use bit u for channel u.
interface writeback_arbiter_if #(
    parameter int NUM_UNITS  = 4,
    parameter int DATA_W     = 64,
    parameter int REG_ADDR_W = 6,
    parameter int FU_CODE_W  = 3
) ();
    localparam int GRANT_W = $clog2(NUM_UNITS);

    logic [NUM_UNITS-1:0]            valid_i;
    logic [NUM_UNITS-1:0]            ready_o;
    logic [NUM_UNITS*FU_CODE_W-1:0]  functionalUnitCode_i;
    logic [NUM_UNITS-1:0]            reg1WritebackEnable_i;
    logic [NUM_UNITS-1:0]            reg2WritebackEnable_i;
    logic [NUM_UNITS*REG_ADDR_W-1:0] reg1WritebackAddress_i;
    logic [NUM_UNITS*REG_ADDR_W-1:0] reg2WritebackAddress_i;
    logic [NUM_UNITS*DATA_W-1:0]     reg1WritebackVal_i;
    logic [NUM_UNITS*DATA_W-1:0]     reg2WritebackVal_i;
    logic                            writebackStall_i;

    logic                            valid_o;
    logic [GRANT_W-1:0]              grantUnit_o;
    logic [FU_CODE_W-1:0]            functionalUnitCode_o;
    logic                            reg1WritebackEnable_o;
    logic                            reg2WritebackEnable_o;
    logic [REG_ADDR_W-1:0]           reg1WritebackAddress_o;
    logic [REG_ADDR_W-1:0]           reg2WritebackAddress_o;
    logic [DATA_W-1:0]               reg1WritebackVal_o;
    logic [DATA_W-1:0]               reg2WritebackVal_o;

    modport slave (
        input  valid_i, functionalUnitCode_i,
        input  reg1WritebackEnable_i, reg2WritebackEnable_i,
        input  reg1WritebackAddress_i, reg2WritebackAddress_i,
        input  reg1WritebackVal_i, reg2WritebackVal_i, writebackStall_i,
        output ready_o, valid_o, grantUnit_o, functionalUnitCode_o,
        output reg1WritebackEnable_o, reg2WritebackEnable_o,
        output reg1WritebackAddress_o, reg2WritebackAddress_o,
        output reg1WritebackVal_o, reg2WritebackVal_o
    );

    modport master (
        output valid_i, functionalUnitCode_i,
        output reg1WritebackEnable_i, reg2WritebackEnable_i,
        output reg1WritebackAddress_i, reg2WritebackAddress_i,
        output reg1WritebackVal_i, reg2WritebackVal_i, writebackStall_i,
        input  ready_o, valid_o, grantUnit_o, functionalUnitCode_o,
        input  reg1WritebackEnable_o, reg2WritebackEnable_o,
        input  reg1WritebackAddress_o, reg2WritebackAddress_o,
        input  reg1WritebackVal_o, reg2WritebackVal_o
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Per-unit writeback FIFOs feeding one registered register-file write port,
// serviced round-robin with downstream stall support.
module writeback_arbiter #(
    parameter int NUM_UNITS  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 64,
    parameter int REG_ADDR_W = 6,
    parameter int FU_CODE_W  = 3
) (
    input  logic              clock_i,
    input  logic              reset_i,
    writeback_arbiter_if.slave wb
);
    localparam int GRANT_W = $clog2(NUM_UNITS);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = FU_CODE_W + 2 + 2 * REG_ADDR_W + 2 * DATA_W;

    logic [NUM_UNITS-1:0] ready_vec;
    logic [NUM_UNITS-1:0] nonempty;
    logic [NUM_UNITS-1:0] push;
    logic [NUM_UNITS-1:0] pop;
    logic [ENTRY_W-1:0]   head_entry [NUM_UNITS];

    logic                 grant_found;
    logic [GRANT_W-1:0]   grant_idx;
    logic [GRANT_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic                 out_valid_reg, out_valid_next;
    logic [GRANT_W-1:0]   out_grant_reg, out_grant_next;
    logic [ENTRY_W-1:0]   out_entry_reg, out_entry_next;

    generate
        for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_chan
            localparam int HI = NUM_UNITS - 1 - gi;

            logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
            logic [PTR_W-1:0]   wr_ptr_reg;
            logic [PTR_W-1:0]   rd_ptr_reg;
            logic [CNT_W-1:0]   count_reg;
            logic [ENTRY_W-1:0] in_entry;
            logic               has_write;

            assign in_entry = {
                wb.functionalUnitCode_i[HI*FU_CODE_W +: FU_CODE_W],
                wb.reg1WritebackEnable_i[gi],
                wb.reg2WritebackEnable_i[gi],
                wb.reg1WritebackAddress_i[HI*REG_ADDR_W +: REG_ADDR_W],
                wb.reg2WritebackAddress_i[HI*REG_ADDR_W +: REG_ADDR_W],
                wb.reg1WritebackVal_i[HI*DATA_W +: DATA_W],
                wb.reg2WritebackVal_i[HI*DATA_W +: DATA_W]
            };

            // A beat with neither enable set is handshaken but carries nothing to write.
            assign has_write     = wb.reg1WritebackEnable_i[gi] | wb.reg2WritebackEnable_i[gi];
            assign ready_vec[gi] = !reset_i && (count_reg != CNT_W'(FIFO_DEPTH));
            assign push[gi]      = wb.valid_i[gi] && ready_vec[gi] && has_write;
            assign pop[gi]       = grant_found && !wb.writebackStall_i && (grant_idx == GRANT_W'(gi));
            assign nonempty[gi]  = (count_reg != '0);
            assign head_entry[gi] = mem[rd_ptr_reg];

            always_ff @(posedge clock_i) begin
                if (reset_i) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    case ({push[gi], pop[gi]})
                        2'b10:   count_reg <= count_reg + 1'b1;
                        2'b01:   count_reg <= count_reg - 1'b1;
                        default: count_reg <= count_reg;
                    endcase
                end
            end

            // Storage carries no reset; stale contents are unreachable once pointers clear.
            always_ff @(posedge clock_i) begin
                if (push[gi]) mem[wr_ptr_reg] <= in_entry;
            end
        end
    endgenerate

    assign wb.ready_o = ready_vec;

    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
            if (!grant_found && nonempty[idx]) begin
                grant_found = 1'b1;
                grant_idx   = GRANT_W'(idx);
            end
        end
    end

    always_comb begin
        rr_ptr_next    = rr_ptr_reg;
        out_valid_next = out_valid_reg;
        out_grant_next = out_grant_reg;
        out_entry_next = out_entry_reg;
        if (!wb.writebackStall_i) begin
            if (grant_found) begin
                out_valid_next = 1'b1;
                out_grant_next = grant_idx;
                out_entry_next = head_entry[grant_idx];
                rr_ptr_next    = (grant_idx == GRANT_W'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;
            end else begin
                out_valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rr_ptr_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_grant_reg <= '0;
            out_entry_reg <= '0;
        end else begin
            rr_ptr_reg    <= rr_ptr_next;
            out_valid_reg <= out_valid_next;
            out_grant_reg <= out_grant_next;
            out_entry_reg <= out_entry_next;
        end
    end

    assign wb.valid_o     = out_valid_reg;
    assign wb.grantUnit_o = out_grant_reg;
    assign {wb.functionalUnitCode_o,
            wb.reg1WritebackEnable_o, wb.reg2WritebackEnable_o,
            wb.reg1WritebackAddress_o, wb.reg2WritebackAddress_o,
            wb.reg1WritebackVal_o, wb.reg2WritebackVal_o} = out_entry_reg;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed checks of the writeback arbiter: latency, fairness, backpressure,
// stall hold, mid-operation reset and no-op beats.
module tb_writeback_arbiter;
    localparam int NU = 4;
    localparam int DW = 64;
    localparam int AW = 6;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic srst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    writeback_arbiter_if #(.NUM_UNITS(NU), .DATA_W(DW), .REG_ADDR_W(AW), .FU_CODE_W(CW)) wb ();

    writeback_arbiter #(
        .NUM_UNITS(NU), .FIFO_DEPTH(4), .DATA_W(DW), .REG_ADDR_W(AW), .FU_CODE_W(CW)
    ) dut (
        .clock_i (clk),
        .reset_i (srst),
        .wb      (wb)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int u, input logic e1, input logic e2,
                            input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                            input logic [DW-1:0] v1, input logic [DW-1:0] v2,
                            input logic [CW-1:0] code);
        wb.valid_i[u] = 1'b1;
        wb.reg1WritebackEnable_i[u] = e1;
        wb.reg2WritebackEnable_i[u] = e2;
        wb.reg1WritebackAddress_i[(NU-1-u)*AW +: AW] = a1;
        wb.reg2WritebackAddress_i[(NU-1-u)*AW +: AW] = a2;
        wb.reg1WritebackVal_i[(NU-1-u)*DW +: DW] = v1;
        wb.reg2WritebackVal_i[(NU-1-u)*DW +: DW] = v2;
        wb.functionalUnitCode_i[(NU-1-u)*CW +: CW] = code;
        $display("drive unit=%0d en=%b%b a1=%0d v1=%0h a2=%0d v2=%0h code=%0d",
                 u, e1, e2, a1, v1, a2, v2, code);
    endtask

    task automatic out_chk(input string tag, input logic vld, input logic [1:0] g,
                           input logic [AW-1:0] a1, input logic [DW-1:0] v1);
        $display("observe %s valid=%b grant=%0d a1=%0d v1=%0h", tag,
                 wb.valid_o, wb.grantUnit_o, wb.reg1WritebackAddress_o, wb.reg1WritebackVal_o);
        chk({tag, ".valid"}, 64'(wb.valid_o), 64'(vld));
        chk({tag, ".grant"}, 64'(wb.grantUnit_o), 64'(g));
        chk({tag, ".addr1"}, 64'(wb.reg1WritebackAddress_o), 64'(a1));
        chk({tag, ".val1"}, wb.reg1WritebackVal_o, v1);
    endtask

    task automatic do_reset();
        srst = 1'b1;
        wb.valid_i = '0;
        wb.writebackStall_i = 1'b0;
        tick();
        tick();
        srst = 1'b0;
        #1;
    endtask

    initial begin
        wb.valid_i = '0;
        wb.functionalUnitCode_i = '0;
        wb.reg1WritebackEnable_i = '0;
        wb.reg2WritebackEnable_i = '0;
        wb.reg1WritebackAddress_i = '0;
        wb.reg2WritebackAddress_i = '0;
        wb.reg1WritebackVal_i = '0;
        wb.reg2WritebackVal_i = '0;
        wb.writebackStall_i = 1'b0;

        // reset state
        tick();
        chk("rst.ready_low", 64'(wb.ready_o), 64'h0);
        tick();
        srst = 1'b0;
        #1;
        chk("rst.ready", 64'(wb.ready_o), 64'hF);
        out_chk("rst.out", 1'b0, 2'd0, 6'd0, 64'h0);
        chk("rst.code", 64'(wb.functionalUnitCode_o), 64'h0);

        // 1: single result with one cycle of FIFO latency
        set_beat(1, 1'b1, 1'b0, 6'd5, 6'd0, 64'h1234, 64'h0, 3'd2);
        tick();
        wb.valid_i = '0;
        chk("t1.no_bypass", 64'(wb.valid_o), 64'h0);
        tick();
        out_chk("t1.out", 1'b1, 2'd1, 6'd5, 64'h1234);
        chk("t1.code", 64'(wb.functionalUnitCode_o), 64'd2);
        chk("t1.en1", 64'(wb.reg1WritebackEnable_o), 64'd1);
        chk("t1.en2", 64'(wb.reg2WritebackEnable_o), 64'd0);
        tick();
        chk("t1.gone", 64'(wb.valid_o), 64'h0);

        // 2: fairness across all units, then interleave units 0 and 2
        do_reset();
        for (int u = 0; u < NU; u++)
            set_beat(u, 1'b1, 1'b1, 6'(u), 6'(u + 8), 64'(16 + u), 64'(32 + u), 3'(u));
        tick();
        wb.valid_i = '0;
        for (int u = 0; u < NU; u++) begin
            tick();
            out_chk($sformatf("t2.rr%0d", u), 1'b1, 2'(u), 6'(u), 64'(16 + u));
            chk($sformatf("t2.rr%0d.a2", u), 64'(wb.reg2WritebackAddress_o), 64'(u + 8));
            chk($sformatf("t2.rr%0d.v2", u), wb.reg2WritebackVal_o, 64'(32 + u));
        end
        set_beat(0, 1'b1, 1'b0, 6'd10, 6'd0, 64'hA0, 64'h0, 3'd1);
        set_beat(2, 1'b1, 1'b0, 6'd20, 6'd0, 64'hC0, 64'h0, 3'd3);
        tick();
        set_beat(0, 1'b1, 1'b0, 6'd11, 6'd0, 64'hA1, 64'h0, 3'd1);
        set_beat(2, 1'b1, 1'b0, 6'd21, 6'd0, 64'hC1, 64'h0, 3'd3);
        tick();
        wb.valid_i = '0;
        out_chk("t2.i0", 1'b1, 2'd0, 6'd10, 64'hA0);
        tick();
        out_chk("t2.i1", 1'b1, 2'd2, 6'd20, 64'hC0);
        tick();
        out_chk("t2.i2", 1'b1, 2'd0, 6'd11, 64'hA1);
        tick();
        out_chk("t2.i3", 1'b1, 2'd2, 6'd21, 64'hC1);
        tick();
        chk("t2.idle", 64'(wb.valid_o), 64'h0);

        // 3: backpressure on a full FIFO under stall
        do_reset();
        wb.writebackStall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_beat(0, 1'b1, 1'b0, 6'(i + 1), 6'd0, 64'(256 + i), 64'h0, 3'd4);
            chk($sformatf("t3.ready_b%0d", i + 1), 64'(wb.ready_o[0]), (i < 4) ? 64'd1 : 64'd0);
            tick();
        end
        wb.valid_i = '0;
        chk("t3.full", 64'(wb.ready_o[0]), 64'd0);
        chk("t3.stalled", 64'(wb.valid_o), 64'd0);
        wb.writebackStall_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            out_chk($sformatf("t3.drain%0d", i), 1'b1, 2'd0, 6'(i + 1), 64'(256 + i));
            if (i == 0) chk("t3.ready_back", 64'(wb.ready_o[0]), 64'd1);
        end
        tick();
        chk("t3.beat5_dropped", 64'(wb.valid_o), 64'd0);

        // 4: outputs frozen while stalled
        do_reset();
        set_beat(0, 1'b1, 1'b0, 6'd7, 6'd0, 64'hAA, 64'h0, 3'd5);
        tick();
        set_beat(0, 1'b1, 1'b0, 6'd8, 6'd0, 64'hBB, 64'h0, 3'd5);
        tick();
        wb.valid_i = '0;
        out_chk("t4.pre", 1'b1, 2'd0, 6'd7, 64'hAA);
        wb.writebackStall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            out_chk($sformatf("t4.hold%0d", i), 1'b1, 2'd0, 6'd7, 64'hAA);
        end
        wb.writebackStall_i = 1'b0;
        tick();
        out_chk("t4.next", 1'b1, 2'd0, 6'd8, 64'hBB);
        tick();
        chk("t4.idle", 64'(wb.valid_o), 64'd0);

        // 5: reset discards queued and in-flight results
        do_reset();
        wb.writebackStall_i = 1'b1;
        set_beat(1, 1'b1, 1'b0, 6'd1, 6'd0, 64'h51, 64'h0, 3'd0);
        set_beat(3, 1'b1, 1'b0, 6'd3, 6'd0, 64'h53, 64'h0, 3'd0);
        tick();
        wb.valid_i = '0;
        set_beat(1, 1'b1, 1'b0, 6'd2, 6'd0, 64'h52, 64'h0, 3'd0);
        tick();
        wb.valid_i = '0;
        wb.writebackStall_i = 1'b0;
        tick();
        out_chk("t5.pre", 1'b1, 2'd1, 6'd1, 64'h51);
        srst = 1'b1;
        #1;
        chk("t5.ready_in_rst", 64'(wb.ready_o), 64'h0);
        tick();
        chk("t5.valid_rst", 64'(wb.valid_o), 64'h0);
        chk("t5.grant_rst", 64'(wb.grantUnit_o), 64'h0);
        chk("t5.ready_rst2", 64'(wb.ready_o), 64'h0);
        srst = 1'b0;
        #1;
        chk("t5.ready_after", 64'(wb.ready_o), 64'hF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t5.lost%0d", i), 64'(wb.valid_o), 64'h0);
        end

        // 6: beat with no enables is accepted but never issued
        set_beat(2, 1'b0, 1'b0, 6'd9, 6'd9, 64'hDEAD, 64'hBEEF, 3'd6);
        chk("t6.ready_pre", 64'(wb.ready_o[2]), 64'd1);
        tick();
        wb.valid_i = '0;
        chk("t6.ready_post", 64'(wb.ready_o), 64'hF);
        chk("t6.v0", 64'(wb.valid_o), 64'h0);
        tick();
        chk("t6.v1", 64'(wb.valid_o), 64'h0);
        tick();
        chk("t6.v2", 64'(wb.valid_o), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
